// File: rtl/instr_queue.sv
// Instruction queue between the fetch return port and decode: a circular FIFO of
// {instr, pc, bubble, exc} with epoch-based discard of stale returns and fetch credits.
module instr_queue #(
  parameter int WIDTH = 32,
  parameter int PC_W  = 32,
  parameter int EXC_W = 8,
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clk_en,
  input  logic                     halt,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_epoch,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     in_bubble,
  input  logic [EXC_W-1:0]         in_exc,
  input  logic                     stall,
  output logic                     fetch_ready,
  output logic                     epoch,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic                     out_bubble,
  output logic [EXC_W-1:0]         out_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_instr  [DEPTH];
  logic [PC_W-1:0]  mem_pc     [DEPTH];
  logic             mem_bubble [DEPTH];
  logic [EXC_W-1:0] mem_exc    [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic          advance;
  logic          accept;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] free_slots;

  assign advance = clk_en && !halt;
  assign accept  = in_valid && (in_epoch == epoch);
  assign full    = (count == CW'(DEPTH));
  assign pop     = out_valid && !stall;
  // A full queue still takes a new entry when the head leaves in the same cycle.
  assign push    = accept && (!full || pop);
  assign drop    = accept && !push;

  assign free_slots  = CW'(DEPTH) - count;
  assign fetch_ready = (free_slots > CW'(SKID));

  assign out_valid  = (count != '0);
  assign out_instr  = out_valid ? mem_instr[head] : '0;
  assign out_pc     = out_valid ? mem_pc[head]    : '0;
  assign out_exc    = out_valid ? mem_exc[head]   : '0;
  assign out_bubble = out_valid ? mem_bubble[head] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      epoch        <= 1'b0;
      overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i]  <= '0;
        mem_pc[i]     <= '0;
        mem_bubble[i] <= 1'b0;
        mem_exc[i]    <= '0;
      end
    end else if (advance) begin
      if (flush) begin
        // Returns arriving during the flush belong to the old stream and are dropped.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        epoch <= ~epoch;
      end else begin
        if (push) begin
          mem_instr[tail]  <= in_instr;
          mem_pc[tail]     <= in_pc;
          mem_bubble[tail] <= in_bubble;
          mem_exc[tail]    <= in_exc;
          tail             <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if (drop) begin
          overflow_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: stimulus feeds a queue-based reference model,
// a negedge monitor compares the DUT against it and retires consumed entries.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int SKID  = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bubble;
    logic [7:0]  exc;
  } ent_t;

  logic        clk;
  logic        rst_n, clk_en, halt, flush;
  logic        in_valid, in_epoch, in_bubble, stall;
  logic [31:0] in_instr, in_pc;
  logic [7:0]  in_exc;
  logic        fetch_ready, epoch, out_valid, out_bubble, overflow_err;
  logic [31:0] out_instr, out_pc;
  logic [7:0]  out_exc;
  logic [2:0]  count;

  instr_queue #(.WIDTH(32), .PC_W(32), .EXC_W(8), .DEPTH(DEPTH), .SKID(SKID)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_epoch(in_epoch), .in_instr(in_instr), .in_pc(in_pc),
    .in_bubble(in_bubble), .in_exc(in_exc), .stall(stall),
    .fetch_ready(fetch_ready), .epoch(epoch), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_bubble(out_bubble),
    .out_exc(out_exc), .count(count), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t sb_q[$];
  bit   m_epoch;
  bit   m_ovf;
  bit   mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: DUT state after the last edge versus the model, then retire the head
  // if the inputs now present make the next edge consume it.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("count", 64'(count), 64'(sb_q.size()));
      chk("epoch", 64'(epoch), 64'(m_epoch));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
      chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - sb_q.size()) > SKID));
      if (sb_q.size() > 0) begin
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_instr", 64'(out_instr), 64'(sb_q[0].instr));
        chk("out_pc", 64'(out_pc), 64'(sb_q[0].pc));
        chk("out_bubble", 64'(out_bubble), 64'(sb_q[0].bubble));
        chk("out_exc", 64'(out_exc), 64'(sb_q[0].exc));
        if (rst_n && !halt && clk_en && !flush && !stall) void'(sb_q.pop_front());
      end else begin
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_bubble", 64'(out_bubble), 64'd1);
        chk("empty_instr", 64'(out_instr), 64'd0);
        chk("empty_pc", 64'(out_pc), 64'd0);
        chk("empty_exc", 64'(out_exc), 64'd0);
      end
    end
  end

  // Model effect of the coming edge on storage/epoch/overflow (pop already retired).
  task automatic model_update();
    ent_t e;
    if (!rst_n) begin
      sb_q.delete();
      m_epoch = 1'b0;
      m_ovf   = 1'b0;
    end else if (halt || !clk_en) begin
      // frozen
    end else if (flush) begin
      sb_q.delete();
      m_epoch = ~m_epoch;
    end else if (in_valid && (in_epoch == m_epoch)) begin
      if (sb_q.size() < DEPTH) begin
        e.instr = in_instr; e.pc = in_pc; e.bubble = in_bubble; e.exc = in_exc;
        sb_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; in_epoch = m_epoch; in_instr = '0; in_pc = '0;
    in_bubble = 0; in_exc = '0; flush = 0; halt = 0; clk_en = 1; rst_n = 1;
  endtask

  task automatic drive_push(logic [31:0] pc, bit ep, bit bub, logic [7:0] exc);
    in_valid = 1; in_epoch = ep; in_instr = $urandom; in_pc = pc;
    in_bubble = bub; in_exc = exc;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) begin
      idle_in();
      step();
    end
  endtask

  initial begin
    m_epoch = 0; m_ovf = 0;
    idle_in();
    rst_n = 0; stall = 0;
    step();
    mon_on = 1;

    // In-order flow with no back-pressure.
    for (int i = 0; i < 4; i++) begin
      idle_in(); stall = 0;
      drive_push(32'h100 + 32'(4 * i), m_epoch, 0, 0);
      step();
    end
    idle_cycles(2);

    // Fill under stall, overflow on the fifth return, then drain.
    for (int i = 0; i < 5; i++) begin
      idle_in(); stall = 1;
      drive_push(32'h100 + 32'(4 * i), m_epoch, 0, 0);
      step();
      if (i == 1) chk("fetch_ready_after_2", 64'(fetch_ready), 64'd0);
    end
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("head_after_ovf", 64'(out_pc), 64'h100);
    idle_in(); stall = 0;
    idle_cycles(5);

    // Full queue with a simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      idle_in(); stall = 1;
      drive_push(32'h300 + 32'(4 * i), m_epoch, 0, 0);
      step();
    end
    idle_in(); stall = 0;
    drive_push(32'h310, m_epoch, 0, 0);
    step();
    chk("count_full_pushpop", 64'(count), 64'd4);
    idle_in(); stall = 0;
    idle_cycles(5);

    // Flush with stale returns afterwards.
    for (int i = 0; i < 3; i++) begin
      idle_in(); stall = 1;
      drive_push(32'h180 + 32'(4 * i), m_epoch, 0, 0);
      step();
    end
    idle_in(); flush = 1; stall = 0;
    drive_push(32'h1F0, m_epoch, 0, 0);
    step();
    chk("flush_epoch", 64'(epoch), 64'd1);
    chk("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 2; i++) begin
      idle_in(); stall = 0;
      drive_push(32'h1E0 + 32'(4 * i), 1'b0, 0, 0);
      step();
    end
    idle_in(); stall = 0;
    drive_push(32'h200, m_epoch, 0, 0);
    step();
    chk("new_epoch_pc", 64'(out_pc), 64'h200);
    idle_cycles(3);

    // Halt and clock-enable freeze.
    for (int i = 0; i < 2; i++) begin
      idle_in(); stall = 1;
      drive_push(32'h100 + 32'(4 * i), m_epoch, 0, 0);
      step();
    end
    for (int i = 0; i < 6; i++) begin
      idle_in(); stall = 0; flush = 1;
      if (i < 3) halt = 1; else clk_en = 0;
      drive_push(32'h500, m_epoch, 0, 0);
      step();
    end
    chk("resume_pc", 64'(out_pc), 64'h100);
    idle_in(); stall = 0;
    idle_cycles(4);

    // Exception payload, then reset overriding halt.
    idle_in(); stall = 1;
    drive_push(32'h400, m_epoch, 0, 8'h81);
    step();
    chk("exc_head", 64'(out_exc), 64'h81);
    chk("exc_bubble", 64'(out_bubble), 64'd0);
    idle_in(); rst_n = 0; halt = 1; stall = 1;
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_epoch", 64'(epoch), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      idle_in();
      stall  = ($urandom_range(99) < 40);
      flush  = ($urandom_range(99) < 3);
      halt   = ($urandom_range(99) < 5);
      clk_en = ($urandom_range(99) < 90);
      rst_n  = ($urandom_range(199) != 0);
      if ($urandom_range(99) < 65)
        drive_push($urandom, ($urandom_range(9) == 0) ? ~m_epoch : m_epoch,
                   1'($urandom_range(1)), ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00);
      step();
    end
    idle_cycles(6);

    mon_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
